// File: rtl/hud_pkg.sv
// hud_pkg: colours, screen geometry, KO box/glyph and FSM states shared by the status-bar HUD
package hud_pkg;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] RED = 16'hF800;
  localparam logic [15:0] BLUE = 16'h001F;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam int OLED_W = 96;
  localparam int OLED_H = 64;
  localparam int KO_X0 = 42;
  localparam int KO_X1 = 53;
  localparam int KO_Y0 = 2;
  localparam int KO_Y1 = 9;
  typedef enum logic [1:0] {IDLE, KO_BLINK, KO_HOLD} ko_state_e;
  // ko_glyph ROM: one word per box row, bit n lights column n of the 12x8 KO box
  localparam logic [11:0] KO_GLYPH [8] = '{12'h000, 12'h312, 12'h48A, 12'h486,
                                          12'h486, 12'h48A, 12'h312, 12'h000};
  function automatic logic ko_glyph(input logic [3:0] gx, input logic [2:0] gy);
    return KO_GLYPH[gy][gx];
  endfunction
endpackage

// File: rtl/status_bar_engine_trail.sv
// hb_trail: clamps one player's health, animates its damage trail and registers both fill lengths
module hb_trail import hud_pkg::*; #(
  parameter int HEALTH_W = 9,
  parameter int MAX_HEALTH = 400,
  parameter int BAR_LEN = 40,
  parameter int DRAIN_STEP = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           round_reset,
  input  logic                           tick,
  input  logic [HEALTH_W-1:0]            curr,
  output logic [HEALTH_W-1:0]            trail,
  output logic [$clog2(BAR_LEN+1)-1:0]   fill_h,
  output logic [$clog2(BAR_LEN+1)-1:0]   fill_t
);
  localparam int FW = $clog2(BAR_LEN + 1);
  localparam logic [HEALTH_W-1:0] MAX_H = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] STEP = HEALTH_W'(DRAIN_STEP);
  logic [HEALTH_W-1:0] h, trail_d, trail_q;
  logic [FW-1:0] fill_h_d, fill_h_q, fill_t_d, fill_t_q;
  function automatic logic [FW-1:0] fill_len(input logic [HEALTH_W-1:0] v);
    return FW'((32'(v) * BAR_LEN) / MAX_HEALTH);
  endfunction
  // heals snap up at once; damage only drains on ticks and stops exactly at h
  always_comb begin
    h = curr > MAX_H ? MAX_H : curr;
    trail_d = round_reset ? MAX_H
            : h > trail_q ? h
            : tick && trail_q > h ? (trail_q - h > STEP ? trail_q - STEP : h)
            : trail_q;
    fill_h_d = fill_len(h);
    fill_t_d = fill_len(trail_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trail_q <= MAX_H;
      fill_h_q <= '0;
      fill_t_q <= FW'(BAR_LEN);
    end else begin
      trail_q <= trail_d;
      fill_h_q <= fill_h_d;
      fill_t_q <= fill_t_d;
    end
  assign trail = trail_q;
  assign fill_h = fill_h_q;
  assign fill_t = fill_t_q;
endmodule

// File: rtl/status_bar_engine.sv
// status_bar_engine: two-player health-bar renderer with damage trails and a blinking KO banner
module status_bar_engine import hud_pkg::*; #(
  parameter int HEALTH_W = 9,
  parameter int MAX_HEALTH = 400,
  parameter int BAR_LEN = 40,
  parameter int BAR_MARGIN = 1,
  parameter int BAR_Y = 2,
  parameter int BAR_H = 6,
  parameter int DRAIN_STEP = 4,
  parameter int TICK_DIV = 2_500_000,
  parameter int BLINK_TICKS = 4,
  parameter int BLINK_COUNT = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                round_reset,
  input  logic [HEALTH_W-1:0] curr_health_l,
  input  logic [HEALTH_W-1:0] curr_health_r,
  input  logic [12:0]         pixel_index,
  output logic [15:0]         oled_colour,
  output logic [HEALTH_W-1:0] final_health_l,
  output logic [HEALTH_W-1:0] final_health_r,
  output logic                ko_active,
  output logic [1:0]          ko_winner
);
  localparam int FW = $clog2(BAR_LEN + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int PW = $clog2(BLINK_COUNT + 1);
  localparam int R_X1 = OLED_W - 1 - BAR_MARGIN;
  localparam int R_X0 = R_X1 - BAR_LEN + 1;
  localparam int L_X0 = BAR_MARGIN;
  localparam int L_X1 = BAR_MARGIN + BAR_LEN - 1;
  ko_state_e state_d, state_q;
  logic [TW-1:0] cnt_d, cnt_q;
  logic [BW-1:0] bt_d, bt_q;
  logic [PW-1:0] ph_d, ph_q;
  logic [1:0] win_d, win_q;
  logic [15:0] colour_d, colour_q;
  logic tick, glyph_vis, in_box, in_rows, l0, r0;
  logic [HEALTH_W-1:0] trail_l, trail_r;
  logic [FW-1:0] fh_l, ft_l, fh_r, ft_r;
  int x, y;
  hb_trail #(.HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .BAR_LEN(BAR_LEN), .DRAIN_STEP(DRAIN_STEP))
    u_trail_l (.clk(clk), .rst_n(rst_n), .round_reset(round_reset), .tick(tick),
               .curr(curr_health_l), .trail(trail_l), .fill_h(fh_l), .fill_t(ft_l));
  hb_trail #(.HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .BAR_LEN(BAR_LEN), .DRAIN_STEP(DRAIN_STEP))
    u_trail_r (.clk(clk), .rst_n(rst_n), .round_reset(round_reset), .tick(tick),
               .curr(curr_health_r), .trail(trail_r), .fill_h(fh_r), .fill_t(ft_r));
  function automatic logic [15:0] bar_px(input int d, input logic [FW-1:0] fh, input logic [FW-1:0] ft);
    return d < int'(fh) ? YELLOW : d < int'(ft) ? RED : BLUE;
  endfunction
  assign tick = cnt_q == TW'(TICK_DIV - 1);
  assign cnt_d = round_reset || tick ? '0 : cnt_q + 1'b1;
  assign l0 = trail_l == '0;
  assign r0 = trail_r == '0;
  assign glyph_vis = state_q == KO_HOLD || (state_q == KO_BLINK && !ph_q[0]);
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    bt_d = bt_q;
    ph_d = ph_q;
    if (round_reset) begin
      state_d = IDLE;
      win_d = 2'b00;
      bt_d = '0;
      ph_d = '0;
    end else
      case (state_q)
        IDLE: if (l0 || r0) begin
          state_d = KO_BLINK;
          win_d = {l0, r0};
          bt_d = '0;
          ph_d = '0;
        end
        KO_BLINK: if (tick) begin
          bt_d = bt_q == BW'(BLINK_TICKS - 1) ? '0 : bt_q + 1'b1;
          ph_d = bt_q == BW'(BLINK_TICKS - 1) ? ph_q + 1'b1 : ph_q;
          state_d = bt_q == BW'(BLINK_TICKS - 1) && ph_q == PW'(BLINK_COUNT - 1) ? KO_HOLD : KO_BLINK;
        end
        KO_HOLD: state_d = KO_HOLD;
        default: state_d = IDLE;
      endcase
  end
  // bar distances are measured from each screen edge so the left bar mirrors the right
  always_comb begin
    x = int'(pixel_index) % OLED_W;
    y = int'(pixel_index) / OLED_W;
    in_box = x >= KO_X0 && x <= KO_X1 && y >= KO_Y0 && y <= KO_Y1;
    in_rows = y >= BAR_Y && y < BAR_Y + BAR_H;
    colour_d = in_box && glyph_vis && ko_glyph(4'(x - KO_X0), 3'(y - KO_Y0)) ? WHITE
             : in_box ? RED
             : in_rows && x >= R_X0 && x <= R_X1 ? bar_px(R_X1 - x, fh_r, ft_r)
             : in_rows && x >= L_X0 && x <= L_X1 ? bar_px(x - L_X0, fh_l, ft_l)
             : BLACK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bt_q <= '0;
      ph_q <= '0;
      win_q <= 2'b00;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bt_q <= bt_d;
      ph_q <= ph_d;
      win_q <= win_d;
      colour_q <= colour_d;
    end
  assign oled_colour = colour_q;
  assign final_health_l = trail_l;
  assign final_health_r = trail_r;
  assign ko_active = state_q != IDLE;
  assign ko_winner = win_q;
endmodule

// File: tb/tb_status_bar_engine.sv
// tb_status_bar_engine: scenario tasks for trails, bar pixels, KO blinking and both resets
module tb_status_bar_engine;
  import hud_pkg::*;
  logic clk = 0, rst_n = 0, round_reset = 0;
  logic [8:0] curr_health_l = 9'd400, curr_health_r = 9'd400;
  logic [8:0] final_health_l, final_health_r;
  logic [12:0] pixel_index = '0;
  logic [15:0] oled_colour;
  logic ko_active;
  logic [1:0] ko_winner;
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] exp_q[$];

  status_bar_engine #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .round_reset(round_reset),
    .curr_health_l(curr_health_l), .curr_health_r(curr_health_r),
    .pixel_index(pixel_index), .oled_colour(oled_colour),
    .final_health_l(final_health_l), .final_health_r(final_health_r),
    .ko_active(ko_active), .ko_winner(ko_winner));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send_px(input int x, input int y, input logic [15:0] e);
    @(negedge clk);
    pixel_index = 13'(y * 96 + x);
    exp_q.push_back(e);
  endtask

  task automatic get_px(output logic [15:0] got, output logic [15:0] e);
    @(negedge clk);
    got = oled_colour;
    e = 16'hxxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic wait_trail(input bit right, input int v, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = (right ? int'(final_health_r) : int'(final_health_l)) == v;
    end
  endtask

  task automatic wait_ko(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = ko_active === 1'b1;
    end
  endtask

  task automatic test_reset;
    int tbl[5][3] = '{'{94, 3, 16'hFFE0}, '{1, 3, 16'hFFE0}, '{43, 4, 16'hF800},
                      '{0, 0, 16'h0000}, '{94, 8, 16'h0000}};
    logic [15:0] got, e;
    repeat (3) @(negedge clk);
    total++; if (final_health_l !== 9'd400) begin bad++; $display("FAIL reset_trail_l got=%0d want=400", final_health_l); end
    total++; if (final_health_r !== 9'd400) begin bad++; $display("FAIL reset_trail_r got=%0d want=400", final_health_r); end
    total++; if (ko_active !== 1'b0) begin bad++; $display("FAIL reset_ko_active got=%b want=0", ko_active); end
    total++; if (ko_winner !== 2'b00) begin bad++; $display("FAIL reset_winner got=%b want=00", ko_winner); end
    total++; if (oled_colour !== 16'h0) begin bad++; $display("FAIL reset_colour got=%h want=0000", oled_colour); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send_px(tbl[i][0], tbl[i][1], 16'(tbl[i][2]));
      get_px(got, e);
      total++; if (got !== e) begin bad++; $display("FAIL reset_px%0d got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_drain;
    int tbl[5][3] = '{'{74, 3, 16'hF800}, '{55, 3, 16'h001F}, '{94, 3, 16'hFFE0},
                      '{54, 3, 16'h0000}, '{40, 3, 16'hFFE0}};
    logic [15:0] got, e;
    bit ok;
    int t0, t1;
    @(negedge clk);
    curr_health_r = 9'd200;
    wait_trail(1, 396, 20, ok);
    t0 = cyc;
    total++; if (!ok) begin bad++; $display("FAIL drain_first_step got=%0d want=396", final_health_r); end
    wait_trail(1, 360, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_360 got=%0d want=360", final_health_r); end
    for (int i = 0; i < 5; i++) begin
      send_px(tbl[i][0], tbl[i][1], 16'(tbl[i][2]));
      get_px(got, e);
      total++; if (got !== e) begin bad++; $display("FAIL drain_px%0d got=%h want=%h", i, got, e); end
    end
    wait_trail(1, 200, 250, ok);
    t1 = cyc;
    total++; if (!ok || t1 - t0 != 196) begin bad++; $display("FAIL drain_time got=%0d want=196 reached=%0d", t1 - t0, ok); end
    repeat (12) @(negedge clk);
    total++; if (final_health_r !== 9'd200) begin bad++; $display("FAIL drain_floor got=%0d want=200", final_health_r); end
  endtask

  task automatic test_heal;
    int tbl[3][3] = '{'{74, 3, 16'hFFE0}, '{64, 3, 16'h001F}, '{65, 3, 16'hFFE0}};
    logic [15:0] got, e;
    bit ok;
    @(negedge clk);
    curr_health_r = 9'd100;
    wait_trail(1, 180, 120, ok);
    total++; if (!ok) begin bad++; $display("FAIL heal_middrain got=%0d want=180", final_health_r); end
    curr_health_r = 9'd300;
    @(negedge clk);
    total++; if (final_health_r !== 9'd300) begin bad++; $display("FAIL heal_snap got=%0d want=300", final_health_r); end
    for (int i = 0; i < 3; i++) begin
      send_px(tbl[i][0], tbl[i][1], 16'(tbl[i][2]));
      get_px(got, e);
      total++; if (got !== e) begin bad++; $display("FAIL heal_px%0d got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_ko_single;
    logic [15:0] prev, got, e;
    int tq[$];
    int odd = 0;
    bit ok;
    @(negedge clk);
    pixel_index = 13'(4 * 96 + 43);
    curr_health_l = 9'd2;
    wait_trail(0, 2, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL ko_trail2 got=%0d want=2", final_health_l); end
    curr_health_l = 9'd0;
    ok = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      ok = final_health_l === 9'd0;
      if (!ok && final_health_l !== 9'd2) odd++;
    end
    total++; if (!ok || odd != 0) begin bad++; $display("FAIL ko_no_underflow got=%0d want=0 stray=%0d", final_health_l, odd); end
    wait_ko(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL ko_enter got=%b want=1", ko_active); end
    total++; if (ko_winner !== 2'b10) begin bad++; $display("FAIL ko_winner got=%b want=10", ko_winner); end
    prev = oled_colour;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (oled_colour !== prev) begin tq.push_back(cyc); prev = oled_colour; end
    end
    total++; if (tq.size() != 7) begin bad++; $display("FAIL blink_edges got=%0d want=7", tq.size()); end
    for (int k = 1; k < 6; k++) begin
      total++;
      if (tq.size() <= k + 1 || tq[k+1] - tq[k] != 16) begin
        bad++; $display("FAIL blink_phase%0d got=%0d want=16", k, tq.size() > k + 1 ? tq[k+1] - tq[k] : -1);
      end
    end
    total++; if (oled_colour !== WHITE) begin bad++; $display("FAIL hold_glyph got=%h want=ffff", oled_colour); end
    curr_health_l = 9'd400;
    @(negedge clk);
    total++; if (final_health_l !== 9'd400) begin bad++; $display("FAIL hold_heal got=%0d want=400", final_health_l); end
    total++; if (ko_active !== 1'b1 || ko_winner !== 2'b10) begin bad++; $display("FAIL hold_stays got=%b/%b want=1/10", ko_active, ko_winner); end
    send_px(42, 2, RED);
    get_px(got, e);
    total++; if (got !== e) begin bad++; $display("FAIL hold_box got=%h want=%h", got, e); end
  endtask

  task automatic test_round_reset;
    logic [15:0] got, e;
    @(negedge clk);
    round_reset = 1;
    @(negedge clk);
    round_reset = 0;
    total++; if (ko_active !== 1'b0 || ko_winner !== 2'b00) begin bad++; $display("FAIL rr_state got=%b/%b want=0/00", ko_active, ko_winner); end
    total++; if (final_health_l !== 9'd400 || final_health_r !== 9'd400) begin bad++; $display("FAIL rr_trails got=%0d/%0d want=400/400", final_health_l, final_health_r); end
    send_px(43, 4, RED);
    get_px(got, e);
    total++; if (got !== e) begin bad++; $display("FAIL rr_glyph_off got=%h want=%h", got, e); end
    curr_health_r = 9'd400;
  endtask

  task automatic test_double_ko;
    bit ok;
    @(negedge clk);
    curr_health_l = 9'd0;
    curr_health_r = 9'd0;
    wait_ko(600, ok);
    total++; if (!ok) begin bad++; $display("FAIL dko_enter got=%b want=1", ko_active); end
    total++; if (ko_winner !== 2'b11) begin bad++; $display("FAIL dko_winner got=%b want=11", ko_winner); end
    total++; if (final_health_l !== 9'd0 || final_health_r !== 9'd0) begin bad++; $display("FAIL dko_trails got=%0d/%0d want=0/0", final_health_l, final_health_r); end
  endtask

  task automatic test_async_reset;
    repeat (8) @(negedge clk);
    total++; if (ko_active !== 1'b1) begin bad++; $display("FAIL ar_in_blink got=%b want=1", ko_active); end
    @(negedge clk);
    rst_n = 0;
    #1;
    total++; if (oled_colour !== 16'h0) begin bad++; $display("FAIL ar_colour got=%h want=0000", oled_colour); end
    total++; if (ko_active !== 1'b0 || ko_winner !== 2'b00) begin bad++; $display("FAIL ar_state got=%b/%b want=0/00", ko_active, ko_winner); end
    total++; if (final_health_l !== 9'd400 || final_health_r !== 9'd400) begin bad++; $display("FAIL ar_trails got=%0d/%0d want=400/400", final_health_l, final_health_r); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset_in_hold;
    bit ok;
    int dark = 0;
    @(negedge clk);
    pixel_index = 13'(4 * 96 + 43);
    wait_ko(600, ok);
    total++; if (!ok || ko_winner !== 2'b11) begin bad++; $display("FAIL rh_enter got=%b/%b want=1/11", ko_active, ko_winner); end
    repeat (110) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (oled_colour !== WHITE) dark++;
    end
    total++; if (dark != 0) begin bad++; $display("FAIL rh_steady got=%0d want=0", dark); end
    round_reset = 1;
    @(negedge clk);
    round_reset = 0;
    total++; if (ko_active !== 1'b0 || ko_winner !== 2'b00) begin bad++; $display("FAIL rh_state got=%b/%b want=0/00", ko_active, ko_winner); end
    total++; if (final_health_l !== 9'd400 || final_health_r !== 9'd400) begin bad++; $display("FAIL rh_trails got=%0d/%0d want=400/400", final_health_l, final_health_r); end
    total++; if (oled_colour !== WHITE) begin bad++; $display("FAIL rh_colour_live got=%h want=ffff", oled_colour); end
    @(negedge clk);
    total++; if (oled_colour !== RED) begin bad++; $display("FAIL rh_glyph_off got=%h want=f800", oled_colour); end
  endtask

  initial begin
    test_reset;
    test_drain;
    test_heal;
    test_ko_single;
    test_round_reset;
    test_double_ko;
    test_async_reset;
    test_reset_in_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
